// File: rtl/lut_layer_pipe.sv
// Two-stage valid/ready pipeline of runtime-rewritable LUT neurons (LogicNets layer).
// Optional transfer counter (cnt_clr / xfer_cnt) is built only when LUT_LAYER_CNT_EN is defined.
module lut_layer_pipe #(
    parameter int   IN_BITS   = 8,
    parameter int   OUT_BITS  = 1,
    parameter int   N_NEURONS = 4,
    parameter logic INIT_BIT  = 1'b0,
    localparam int  NW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          cfg_we,
    input  logic [NW-1:0]                 cfg_neuron,
    input  logic [IN_BITS-1:0]            cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_data
`ifdef LUT_LAYER_CNT_EN
    ,
    input  logic                          cnt_clr,
    output logic [15:0]                   xfer_cnt
`endif
);

    localparam int DEPTH = 1 << IN_BITS;

    logic [N_NEURONS*IN_BITS-1:0]  r_s1_data;
    logic                          r_v1;
    logic [N_NEURONS*OUT_BITS-1:0] r_s2_data;
    logic                          r_v2;
    logic [N_NEURONS*OUT_BITS-1:0] w_lut;
    logic                          w_en1;
    logic                          w_en2;

    // A stage advances when downstream takes its contents or it holds nothing, so bubbles collapse.
    assign w_en2    = out_ready | ~r_v2;
    assign w_en1    = w_en2 | ~r_v1;
    assign in_ready = w_en1;

    // One table per neuron; a neuron index with no matching table is silently dropped.
    for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
        logic [DEPTH-1:0][OUT_BITS-1:0] r_tbl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tbl <= {(DEPTH*OUT_BITS){INIT_BIT}};
            end else if (cfg_we && (cfg_neuron == NW'(k))) begin
                r_tbl[cfg_addr] <= cfg_data;
            end
        end

        assign w_lut[k*OUT_BITS +: OUT_BITS] = r_tbl[r_s1_data[k*IN_BITS +: IN_BITS]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data <= '0;
            r_v1      <= 1'b0;
            r_s2_data <= '0;
            r_v2      <= 1'b0;
        end else begin
            if (w_en1) begin
                r_s1_data <= in_data;
                r_v1      <= in_valid;
            end
            if (w_en2) begin
                r_s2_data <= w_lut;
                r_v2      <= r_v1;
            end
        end
    end

    assign out_data  = r_s2_data;
    assign out_valid = r_v2;

`ifdef LUT_LAYER_CNT_EN
    logic [15:0] r_xfer_cnt;
    logic        w_fire;

    assign w_fire = r_v2 & out_ready;

    // Clear beats increment; the count sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= 16'h0000;
        end else if (cnt_clr) begin
            r_xfer_cnt <= 16'h0000;
        end else if (w_fire && (r_xfer_cnt != 16'hFFFF)) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Bench for lut_layer_pipe: directed vectors, an in-order expected-result queue model, and literal checks.
// Exercises the transfer counter as well when LUT_LAYER_CNT_EN is defined.
module tb_lut_layer_pipe;

    localparam int   N    = 4;
    localparam int   IB   = 8;
    localparam int   OB   = 1;
    localparam logic INIT = 1'b0;
    localparam int   N3   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic [N*IB-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*OB-1:0] out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_neuron = '0;
    logic [IB-1:0]   cfg_addr = '0;
    logic [OB-1:0]   cfg_data = '0;

    // ---------------- three-neuron DUT signals ----------------
    logic [N3*IB-1:0] d3_in_data = '0;
    logic             d3_in_valid = 1'b0;
    logic             d3_in_ready;
    logic [N3*OB-1:0] d3_out_data;
    logic             d3_out_valid;
    logic             d3_out_ready = 1'b1;
    logic             d3_cfg_we = 1'b0;
    logic [1:0]       d3_cfg_neuron = '0;
    logic [IB-1:0]    d3_cfg_addr = '0;
    logic [OB-1:0]    d3_cfg_data = '0;

`ifdef LUT_LAYER_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] xfer_cnt;
    logic        d3_cnt_clr = 1'b0;
    logic [15:0] d3_xfer_cnt;
`endif

    lut_layer_pipe #(.IN_BITS(IB), .OUT_BITS(OB), .N_NEURONS(N), .INIT_BIT(INIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data)
`ifdef LUT_LAYER_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .xfer_cnt   (xfer_cnt)
`endif
    );

    lut_layer_pipe #(.IN_BITS(IB), .OUT_BITS(OB), .N_NEURONS(N3), .INIT_BIT(INIT)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (d3_in_data),
        .in_valid   (d3_in_valid),
        .in_ready   (d3_in_ready),
        .out_data   (d3_out_data),
        .out_valid  (d3_out_valid),
        .out_ready  (d3_out_ready),
        .cfg_we     (d3_cfg_we),
        .cfg_neuron (d3_cfg_neuron),
        .cfg_addr   (d3_cfg_addr),
        .cfg_data   (d3_cfg_data)
`ifdef LUT_LAYER_CNT_EN
        ,
        .cnt_clr    (d3_cnt_clr),
        .xfer_cnt   (d3_xfer_cnt)
`endif
    );

    // ---------------- scoreboard / model ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_fired = 0;

    logic [N*OB-1:0] exp_q[$];
    logic [OB-1:0]   m_tbl [N][256];
    logic            hold_v = 1'b0;
    logic [N*OB-1:0] hold_d = '0;
`ifdef LUT_LAYER_CNT_EN
    logic [15:0]     m_cnt = '0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out, got no handshake expected one (t=%0t)", nm, $time);
    endtask

    // Each neuron's result is just its own table entry at its own address slice.
    function automatic logic [N*OB-1:0] model_lookup(input logic [N*IB-1:0] v);
        logic [N*OB-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*OB +: OB] = m_tbl[k][v[k*IB +: IB]];
        return r;
    endfunction

    // Compare process: expected results leave the queue in acceptance order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int k = 0; k < N; k++)
                for (int a = 0; a < 256; a++) m_tbl[k][a] = {OB{INIT}};
            hold_v = 1'b0;
`ifdef LUT_LAYER_CNT_EN
            m_cnt = '0;
`endif
        end else begin
            check("in_ready", 32'(in_ready), 32'(out_ready || (exp_q.size() < 2)));
            if (exp_q.size() == 0) check("idle_valid", 32'(out_valid), 32'd0);
            if (hold_v) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_d));
            end
`ifdef LUT_LAYER_CNT_EN
            check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
            if (cnt_clr) m_cnt = '0;
            else if (out_valid && out_ready && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
`endif
            if (out_valid && out_ready) begin
                n_fired++;
                if (exp_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            // A write at this edge is visible to a vector accepted at this same edge.
            if (cfg_we && (int'(cfg_neuron) < N)) m_tbl[cfg_neuron][cfg_addr] = cfg_data;
            if (in_valid && in_ready) exp_q.push_back(model_lookup(in_data));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the accepting posedge with in_valid low.
    task automatic send_vec(input logic [N*IB-1:0] v);
        logic ok;
        ok = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) timeout_fail("send_vec");
    endtask

    task automatic send_and_check(input logic [N*IB-1:0] v, input logic [N*OB-1:0] exp, input string nm);
        send_vec(v);
        @(negedge clk);
        check({nm, "_s1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_data"}, 32'(out_data), 32'(exp));
    endtask

    task automatic cfg_write(input logic [1:0] n, input logic [IB-1:0] a, input logic [OB-1:0] d);
        cfg_we     = 1'b1;
        cfg_neuron = n;
        cfg_addr   = a;
        cfg_data   = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(nm);
    endtask

    // ---------------- directed stimulus ----------------
    logic [N*IB-1:0] vecs [5];
    int fired_before;

    initial begin
        vecs[0] = 32'h12345678;
        vecs[1] = 32'h02000000;
        vecs[2] = 32'h00000100;
        vecs[3] = 32'h02340178;
        vecs[4] = 32'h00000000;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        sync();
        out_ready = 1'b1;
        send_and_check(32'h12345678, 4'h0, "init_lookup");

        sync();
        cfg_write(2'd2, 8'h34, 1'b1);
        cfg_write(2'd0, 8'h78, 1'b1);
        send_and_check(32'h12345678, 4'b0101, "prog_lookup");

        // Vector A sits in S1 at the edge that rewrites neuron 0 / 0x78; vector B follows it.
        sync();
        in_data  = 32'h12345678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 8'h78; cfg_data = 1'b0;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rw_old_data", 32'(out_data), 32'h5);
        @(negedge clk);
        check("rw_new_valid", 32'(out_valid), 32'd1);
        check("rw_new_data", 32'(out_data), 32'h4);
        wait_drain("rw_drain");

        // Backpressure: five vectors against four stalled cycles.
        sync();
        cfg_write(2'd1, 8'h01, 1'b1);
        cfg_write(2'd3, 8'h02, 1'b1);
        fired_before = n_fired;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send_vec(vecs[i]);
            end
            begin
                repeat (3) @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_out_data", 32'(out_data), 32'h4);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("stall_drain");
        check("stall_count", 32'(n_fired - fired_before), 32'd5);

        // Reset with both stages full.
        sync();
        out_ready = 1'b0;
        send_vec(32'h12345678);
        send_vec(32'h02340178);
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_data", 32'(out_data), 32'd0);
        check("rst_async_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send_and_check(32'h02340178, 4'h0, "post_rst_lookup");

        // Three-neuron instance: index 3 has no table, so that write must vanish.
        sync();
        d3_cfg_we = 1'b1; d3_cfg_neuron = 2'd3; d3_cfg_addr = 8'h11; d3_cfg_data = 1'b1;
        @(posedge clk);
        #1;
        d3_cfg_neuron = 2'd1; d3_cfg_addr = 8'h22;
        @(posedge clk);
        #1;
        d3_cfg_we   = 1'b0;
        d3_in_data  = {8'h11, 8'h22, 8'h11};
        d3_in_valid = 1'b1;
        @(posedge clk);
        #1 d3_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("oob_valid", 32'(d3_out_valid), 32'd1);
        check("oob_data", 32'(d3_out_data), 32'h2);

`ifdef LUT_LAYER_CNT_EN
        sync();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_cleared", 32'(xfer_cnt), 32'd0);
        sync();
        for (int i = 0; i < 3; i++) send_vec(vecs[i]);
        wait_drain("cnt_drain");
        check("cnt_three", 32'(xfer_cnt), 32'd3);

        sync();
        in_data  = 32'h00000000;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr_wins", 32'(xfer_cnt), 32'd0);
        wait_drain("cnt_clr_drain");

        sync();
        in_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_drain("cnt_sat_drain");
        check("cnt_saturated", 32'(xfer_cnt), 32'h0000_FFFF);
`endif

        wait_drain("final_drain");
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
